// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned OPCODE_LSB = 2;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: issues one word request, holds the
// returned instruction for decode, and honours redirects at every stage.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_resp_valid,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [XLEN-1:0]     dec_instr,
  output logic [XLEN-1:0]     dec_pc,
  output logic [OPCODE_W-1:0] dec_opcode,
  output logic                dec_illegal,
  output logic [XLEN-1:0]     fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            dec_valid_q, dec_valid_d;
  logic [XLEN-1:0] dec_instr_q, dec_instr_d;
  logic [XLEN-1:0] dec_pc_q, dec_pc_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      dec_valid_q   <= 1'b0;
      dec_instr_q   <= '0;
      dec_pc_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      dec_valid_q   <= dec_valid_d;
      dec_instr_q   <= dec_instr_d;
      dec_pc_q      <= dec_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    dec_valid_d   = dec_valid_q;
    dec_instr_d   = dec_instr_q;
    dec_pc_d      = dec_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        // A redirect that lands together with acceptance must kill the in-flight word.
        if (redirect_valid) begin
          pc_d = redirect_pc_aligned;
          if (imem_req_ready) begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc_aligned;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            dec_instr_d = imem_rdata;
            dec_pc_d    = pc_q;
            dec_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Redirect flushes the held word and takes priority over the decode handshake.
        if (redirect_valid) begin
          dec_valid_d = 1'b0;
          pc_d        = redirect_pc_aligned;
          state_d     = ST_REQ;
        end else if (dec_valid_q && dec_ready) begin
          dec_valid_d   = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_addr      = pc_q;
  assign dec_valid      = dec_valid_q;
  assign dec_instr      = dec_instr_q;
  assign dec_pc         = dec_pc_q;
  assign fetch_count    = fetch_count_q;
  assign dec_opcode     = dec_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign dec_illegal    = (dec_instr_q[1:0] != 2'b11);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: default-reset instance plus a RESET_PC=0xFFFF_FFFC
// instance sharing all inputs, driven cycle by cycle.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;

  logic        req_valid_a, req_valid_b;
  logic [31:0] addr_a, addr_b;
  logic        dv_a, dv_b;
  logic [31:0] di_a, di_b;
  logic [31:0] dp_a, dp_b;
  logic [4:0]  op_a, op_b;
  logic        ill_a, ill_b;
  logic [31:0] cnt_a, cnt_b;

  int checks;
  int failures;

  instr_fetch u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_addr(addr_a),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dv_a), .dec_ready(dec_ready), .dec_instr(di_a), .dec_pc(dp_a),
    .dec_opcode(op_a), .dec_illegal(ill_a), .fetch_count(cnt_a)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_addr(addr_b),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dv_b), .dec_ready(dec_ready), .dec_instr(di_b), .dec_pc(dp_b),
    .dec_opcode(op_b), .dec_illegal(ill_b), .fetch_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    dec_ready       = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_valid_a !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid_a); end
    checks++; if (dv_a !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dv_a); end
    checks++; if (addr_a !== 32'h0) begin failures++; $display("FAIL reset_addr_a got=%h exp=00000000", addr_a); end
    checks++; if (addr_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_addr_b got=%h exp=fffffffc", addr_b); end
    checks++; if (cnt_a !== 32'h0 || di_a !== 32'h0 || dp_a !== 32'h0) begin failures++; $display("FAIL reset_regs cnt=%h instr=%h pc=%h exp=0", cnt_a, di_a, dp_a); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h0) begin failures++; $display("FAIL first_req valid=%b addr=%h exp=1/00000000", req_valid_a, addr_a); end
  endtask

  // Leaves the DUT in REQ at address 4 with fetch_count 1.
  task automatic test_basic_and_stall();
    imem_req_ready = 1'b1;
    tick();
    checks++; if (req_valid_a !== 1'b0) begin failures++; $display("FAIL wait_req_valid got=%b exp=0", req_valid_a); end
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'hDEAD_BEEF;
    checks++; if (dv_a !== 1'b1 || di_a !== 32'h13 || dp_a !== 32'h0) begin failures++; $display("FAIL basic_dec valid=%b instr=%h pc=%h exp=1/00000013/00000000", dv_a, di_a, dp_a); end
    checks++; if (op_a !== 5'b00100 || ill_a !== 1'b0) begin failures++; $display("FAIL basic_opcode op=%b ill=%b exp=00100/0", op_a, ill_a); end
    checks++; if (addr_a !== 32'h4 || req_valid_a !== 1'b0) begin failures++; $display("FAIL basic_next_addr addr=%h rv=%b exp=00000004/0", addr_a, req_valid_a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (dv_a !== 1'b1 || di_a !== 32'h13 || dp_a !== 32'h0 || req_valid_a !== 1'b0 || cnt_a !== 32'h0) begin
        failures++; $display("FAIL stall_%0d dv=%b instr=%h pc=%h rv=%b cnt=%h exp=1/13/0/0/0", i, dv_a, di_a, dp_a, req_valid_a, cnt_a);
      end
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++; if (dv_a !== 1'b0 || cnt_a !== 32'h1) begin failures++; $display("FAIL stall_release dv=%b cnt=%h exp=0/1", dv_a, cnt_a); end
    checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h4) begin failures++; $display("FAIL next_req rv=%b addr=%h exp=1/00000004", req_valid_a, addr_a); end
  endtask

  task automatic test_req_hold();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h4 || dv_a !== 1'b0) begin
        failures++; $display("FAIL req_hold_%0d rv=%b addr=%h dv=%b exp=1/00000004/0", i, req_valid_a, addr_a, dv_a);
      end
    end
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h40) begin failures++; $display("FAIL redirect_req rv=%b addr=%h exp=1/00000040", req_valid_a, addr_a); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b0 || addr_a !== 32'h100) begin failures++; $display("FAIL redirect_wait_pc rv=%b addr=%h exp=0/00000100", req_valid_a, addr_a); end
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (dv_a !== 1'b0 || req_valid_a !== 1'b1 || addr_a !== 32'h100) begin
      failures++; $display("FAIL redirect_wait_drop dv=%b rv=%b addr=%h exp=0/1/00000100", dv_a, req_valid_a, addr_a);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b0 || addr_a !== 32'h300) begin failures++; $display("FAIL redirect_hs rv=%b addr=%h exp=0/00000300", req_valid_a, addr_a); end
    imem_resp_valid = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (dv_a !== 1'b0 || req_valid_a !== 1'b1 || addr_a !== 32'h300) begin
      failures++; $display("FAIL kill_drop dv=%b rv=%b addr=%h exp=0/1/00000300", dv_a, req_valid_a, addr_a);
    end
  endtask

  task automatic test_redirect_hold_and_back_to_back();
    tick();
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0033;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (dv_a !== 1'b1 || dp_a !== 32'h300 || addr_a !== 32'h304 || op_a !== 5'b01100) begin
      failures++; $display("FAIL hold_capture dv=%b pc=%h addr=%h op=%b exp=1/00000300/00000304/01100", dv_a, dp_a, addr_a, op_a);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    dec_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    checks++; if (dv_a !== 1'b0 || cnt_a !== 32'h1) begin failures++; $display("FAIL redirect_hold dv=%b cnt=%h exp=0/1", dv_a, cnt_a); end
    checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h200) begin failures++; $display("FAIL redirect_hold_addr rv=%b addr=%h exp=1/00000200", req_valid_a, addr_a); end
    tick();
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_006F;
    dec_ready       = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (dv_a !== 1'b1 || di_a !== 32'h6F || dp_a !== 32'h200 || op_a !== 5'b11011) begin
      failures++; $display("FAIL b2b_capture dv=%b instr=%h pc=%h op=%b exp=1/0000006f/00000200/11011", dv_a, di_a, dp_a, op_a);
    end
    tick();
    dec_ready = 1'b0;
    checks++; if (cnt_a !== 32'h2 || dv_a !== 1'b0 || addr_a !== 32'h204 || req_valid_a !== 1'b1) begin
      failures++; $display("FAIL b2b_done cnt=%h dv=%b addr=%h rv=%b exp=2/0/00000204/1", cnt_a, dv_a, addr_a, req_valid_a);
    end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    tick();
    checks++; if (req_valid_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_req rv=%b addr=%h exp=1/fffffffc", req_valid_b, addr_b); end
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0000;
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (dv_b !== 1'b1 || ill_b !== 1'b1 || dp_b !== 32'hFFFF_FFFC || addr_b !== 32'h0) begin
      failures++; $display("FAIL wrap_hold dv=%b ill=%b pc=%h addr=%h exp=1/1/fffffffc/00000000", dv_b, ill_b, dp_b, addr_b);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++; if (req_valid_b !== 1'b1 || addr_b !== 32'h0 || cnt_b !== 32'h1) begin
      failures++; $display("FAIL wrap_next rv=%b addr=%h cnt=%h exp=1/00000000/1", req_valid_b, addr_b, cnt_b);
    end
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    checks++; if (req_valid_a !== 1'b0) begin failures++; $display("FAIL rst_wait_setup rv=%b exp=0", req_valid_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_valid_a !== 1'b0 || addr_a !== 32'h0 || dv_a !== 1'b0) begin
      failures++; $display("FAIL rst_async rv=%b addr=%h dv=%b exp=0/00000000/0", req_valid_a, addr_a, dv_a);
    end
    tick();
    rst_n           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h0000_0013;
    tick();
    tick();
    imem_resp_valid = 1'b0;
    checks++; if (req_valid_a !== 1'b1 || addr_a !== 32'h0 || dv_a !== 1'b0 || cnt_a !== 32'h0) begin
      failures++; $display("FAIL rst_late_resp rv=%b addr=%h dv=%b cnt=%h exp=1/00000000/0/0", req_valid_a, addr_a, dv_a, cnt_a);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_and_stall();
    test_req_hold();
    test_redirect_wait();
    test_redirect_hold_and_back_to_back();
    test_pc_wrap();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
